// File: rtl/str_send_if.sv
// Handshake bundle between the result logic, str_send and the UART transmitter.
// Master is the surrounding logic/UART side; slave is str_send itself.
interface str_send_if;
  logic       send;
  logic [7:0] code;
  logic       tx_ready;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       busy;
  logic       done;

  modport master (output send, code, tx_ready, input tx_valid, tx_data, busy, done);
  modport slave  (input send, code, tx_ready, output tx_valid, tx_data, busy, done);
endinterface

// File: rtl/str_send.sv
// Maps a result code to an ASCII keyword and streams it byte-by-byte to the UART TX.
// Optional: define STR_SEND_CRLF_EN to append CR LF after every keyword.
module str_send #(
  parameter int GAP_CYCLES = 0
) (
  input  logic       clk,
  input  logic       rst,
  str_send_if.slave  bus
);
  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_DONE} state_t;

  localparam logic [1:0] SEL_START = 2'd0;
  localparam logic [1:0] SEL_STOP  = 2'd1;
  localparam logic [1:0] SEL_HITSZ = 2'd2;
  localparam logic [1:0] SEL_QM    = 2'd3;
`ifdef STR_SEND_CRLF_EN
  localparam logic [2:0] TAIL = 3'd2;
`else
  localparam logic [2:0] TAIL = 3'd0;
`endif
  localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES);

  state_t     r_state;
  logic [1:0] r_sel;
  logic [2:0] r_idx;
  logic [7:0] r_gap;
  logic       r_tx_valid;
  logic [7:0] r_tx_data;
  logic       r_busy;
  logic       r_done;
  logic [1:0] w_sel_in;
  logic [2:0] w_idx_nxt;

  function automatic logic [1:0] code_sel(input logic [7:0] c);
    case (c)
      8'h31:   return SEL_START;
      8'h32:   return SEL_STOP;
      8'h33:   return SEL_HITSZ;
      default: return SEL_QM;
    endcase
  endfunction

  function automatic logic [2:0] last_idx(input logic [1:0] sel);
    logic [2:0] base;
    case (sel)
      SEL_START: base = 3'd4;
      SEL_STOP:  base = 3'd3;
      SEL_HITSZ: base = 3'd4;
      default:   base = 3'd0;
    endcase
    return base + TAIL;
  endfunction

  function automatic logic [7:0] msg_byte(input logic [1:0] sel, input logic [2:0] idx);
    logic [7:0] b;
    b = 8'h00;
    case (sel)
      SEL_START:
        case (idx)
          3'd0: b = 8'h53;  3'd1: b = 8'h54;  3'd2: b = 8'h41;
          3'd3: b = 8'h52;  3'd4: b = 8'h54;  default: b = 8'h00;
        endcase
      SEL_STOP:
        case (idx)
          3'd0: b = 8'h53;  3'd1: b = 8'h54;  3'd2: b = 8'h4F;
          3'd3: b = 8'h50;  default: b = 8'h00;
        endcase
      SEL_HITSZ:
        case (idx)
          3'd0: b = 8'h48;  3'd1: b = 8'h49;  3'd2: b = 8'h54;
          3'd3: b = 8'h53;  3'd4: b = 8'h5A;  default: b = 8'h00;
        endcase
      default: b = (idx == 3'd0) ? 8'h3F : 8'h00;
    endcase
`ifdef STR_SEND_CRLF_EN
    if (idx == last_idx(sel))              b = 8'h0A;
    else if (idx == last_idx(sel) - 3'd1)  b = 8'h0D;
`endif
    return b;
  endfunction

  assign w_sel_in  = code_sel(bus.code);
  assign w_idx_nxt = r_idx + 3'd1;

  assign bus.tx_valid = r_tx_valid;
  assign bus.tx_data  = r_tx_data;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_sel      <= SEL_START;
      r_idx      <= 3'd0;
      r_gap      <= 8'd0;
      r_tx_valid <= 1'b0;
      r_tx_data  <= 8'h00;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.send) begin
            r_sel      <= w_sel_in;
            r_idx      <= 3'd0;
            r_tx_valid <= 1'b1;
            r_tx_data  <= msg_byte(w_sel_in, 3'd0);
            r_busy     <= 1'b1;
            r_state    <= S_SEND;
          end
        end
        S_SEND: begin
          // tx_data is only advanced on acceptance, so a stalled byte stays put
          if (r_tx_valid && bus.tx_ready) begin
            if (r_idx == last_idx(r_sel)) begin
              r_tx_valid <= 1'b0;
              r_done     <= 1'b1;
              r_state    <= S_DONE;
            end else if (GAP_CYCLES > 0) begin
              r_tx_valid <= 1'b0;
              r_gap      <= GAP_LOAD;
              r_state    <= S_GAP;
            end else begin
              r_idx     <= w_idx_nxt;
              r_tx_data <= msg_byte(r_sel, w_idx_nxt);
            end
          end
        end
        S_GAP: begin
          if (r_gap <= 8'd1) begin
            r_gap      <= 8'd0;
            r_idx      <= w_idx_nxt;
            r_tx_valid <= 1'b1;
            r_tx_data  <= msg_byte(r_sel, w_idx_nxt);
            r_state    <= S_SEND;
          end else begin
            r_gap <= r_gap - 8'd1;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
